pipe_stage: RTL

Parametrised elastic pipeline stage register with valid/ready handshake, optional skid slot, and synchronous flush. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers of the 5-stage core. Stalls propagate as back-pressure instead of ad-hoc hazard enables, and a flush turns the stage into a bubble. One instance sits between every pair of adjacent pipeline stages, with WIDTH set to the packed control plus data bundle of that boundary.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // All-zero payload decodes as a NOP bubble downstream.
  localparam logic PIPE_BUBBLE = '0;

  function automatic logic [1:0] state_occupancy(input pipe_state_t st);
    logic [1:0] occ;
    case (st)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Elastic pipeline stage: valid/ready register with optional skid slot and flush.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid_o=0
// ST_ONE   | main slot holds the presented payload
// ST_FULL  | main + skid slots both hold payloads (SKID=1 only)
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter bit          SKID           = 1'b1,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q;
  logic             load_skid;
  logic             in_fire, out_fire;

  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign occupancy_o = state_occupancy(state_q);

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    load_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A flushed in_fire must not leak into the main slot even when data is kept.
    if (flush_i) begin
      state_d   = ST_EMPTY;
      load_skid = 1'b0;
      main_d    = CLEAR_ON_FLUSH ? {WIDTH{PIPE_BUBBLE}} : main_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= {WIDTH{PIPE_BUBBLE}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          skid_q     <= {WIDTH{PIPE_BUBBLE}};
          in_ready_q <= 1'b1;
        end else begin
          if (flush_i && CLEAR_ON_FLUSH) begin
            skid_q <= {WIDTH{PIPE_BUBBLE}};
          end else if (load_skid) begin
            skid_q <= in_data_i;
          end
          in_ready_q <= (state_d != ST_FULL);
        end
      end

      // Reset gating only; no path from the handshake inputs.
      assign in_ready_o = in_ready_q && !rst_i;
    end else begin : g_single
      assign skid_q     = {WIDTH{PIPE_BUBBLE}};
      assign in_ready_o = !rst_i && ((state_q == ST_EMPTY) || out_ready_i);
    end
  endgenerate

endmodule
